// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-vector helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam logic [1:0]  ST_INIT     = 2'd0;
    localparam logic [1:0]  ST_RUN      = 2'd1;
    localparam logic [1:0]  ST_MEM_WAIT = 2'd2;
    localparam logic [1:0]  ST_ERR      = 2'd3;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] BUBBLE_IR = 32'h0;

    typedef enum logic [1:0] {
        S_INIT     = ST_INIT,
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT,
        S_ERR      = ST_ERR
    } ctrlState_t;

    typedef struct packed {
        logic pcEn;
        logic pcSelTarget;
        logic ifidEn;
        logic idexEn;
        logic exmemEn;
        logic memwbEn;
        logic ifidFlush;
        logic idexFlush;
        logic exmemFlush;
        logic memwbFlush;
        logic dmemReq;
    } ctrlOut_t;

    function automatic ctrlOut_t uniformCtrl(input logic en, input logic flush);
        ctrlOut_t c;
        c.pcEn        = en;
        c.pcSelTarget = 1'b0;
        c.ifidEn      = en;
        c.idexEn      = en;
        c.exmemEn     = en;
        c.memwbEn     = en;
        c.ifidFlush   = flush;
        c.idexFlush   = flush;
        c.exmemFlush  = flush;
        c.memwbFlush  = flush;
        c.dmemReq     = 1'b0;
        return c;
    endfunction

    // Front of the pipe frozen; MEM/WB keeps loading bubbles while the access is outstanding.
    function automatic ctrlOut_t memStallCtrl();
        ctrlOut_t c;
        c            = uniformCtrl(1'b0, 1'b0);
        c.memwbEn    = 1'b1;
        c.memwbFlush = 1'b1;
        c.dmemReq    = 1'b1;
        return c;
    endfunction

    function automatic ctrlOut_t redirectCtrl();
        ctrlOut_t c;
        c             = uniformCtrl(1'b1, 1'b0);
        c.pcSelTarget = 1'b1;
        c.ifidFlush   = 1'b1;
        c.idexFlush   = 1'b1;
        c.exmemFlush  = 1'b1;
        return c;
    endfunction

    function automatic ctrlOut_t loadUseCtrl();
        ctrlOut_t c;
        c           = uniformCtrl(1'b1, 1'b0);
        c.pcEn      = 1'b0;
        c.ifidEn    = 1'b0;
        c.idexFlush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Load-use interlock detector: a load in EX whose destination feeds the instruction in ID.
module pipe_hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset clear, memory wait with timeout,
// redirect and load-use handling. Define PIPE_PERF_CNT_EN to add stall/flush/error counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 5,
    parameter int MEM_TIMEOUT = 64
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W     = 16
`endif
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic       mem_mem_write,
    input  logic       mem_redirect,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       pc_sel_target,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       dmem_req,
    output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrlState_t        state;
    logic [INIT_W-1:0] initCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic              memErr;
    logic              loadUse;
    logic              memAccess;
    logic              memStall;
    logic              timeoutHit;
    ctrlOut_t          runCtrl;
    ctrlOut_t          ctrl;

    pipe_hazard_unit hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (loadUse)
    );

    assign memAccess  = mem_mem_read || mem_mem_write;
    assign memStall   = memAccess && !dmem_ready;
    assign timeoutHit = (state == S_MEM_WAIT) && !dmem_ready &&
                        (waitCnt == WAIT_W'(MEM_TIMEOUT));

    // Redirect outranks load-use: the interlocked instruction is flushed anyway.
    always_comb begin
        runCtrl = uniformCtrl(1'b1, 1'b0);
        if (mem_redirect)
            runCtrl = redirectCtrl();
        else if (loadUse)
            runCtrl = loadUseCtrl();
        runCtrl.dmemReq = memAccess;

        ctrl = uniformCtrl(1'b0, 1'b0);
        unique case (state)
            S_INIT: begin
                ctrl      = uniformCtrl(1'b1, 1'b1);
                ctrl.pcEn = 1'b0;
            end
            S_RUN:      ctrl = memStall ? memStallCtrl() : runCtrl;
            S_MEM_WAIT: begin
                ctrl = dmem_ready ? runCtrl : memStallCtrl();
                ctrl.dmemReq = 1'b1;
            end
            S_ERR:      ctrl = uniformCtrl(1'b0, 1'b0);
            default:    ctrl = uniformCtrl(1'b0, 1'b0);
        endcase
        if (reset)
            ctrl = uniformCtrl(1'b0, 1'b1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_INIT;
            initCnt <= '0;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    if (initCnt == INIT_W'(INIT_CYCLES - 1))
                        state <= S_RUN;
                    else
                        initCnt <= initCnt + 1'b1;
                end
                S_RUN: begin
                    if (memStall) begin
                        state   <= S_MEM_WAIT;
                        waitCnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= S_RUN;
                    end else if (timeoutHit) begin
                        state  <= S_ERR;
                        memErr <= 1'b1;
                    end else if (waitCnt < WAIT_W'(MEM_TIMEOUT)) begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stallCycle;
    assign stallCycle = ((state == S_RUN) || (state == S_MEM_WAIT)) && !ctrl.pcEn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (stallCycle && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ctrl.pcSelTarget && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if (timeoutHit && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

    assign pc_en         = ctrl.pcEn;
    assign pc_sel_target = ctrl.pcSelTarget;
    assign ifid_en       = ctrl.ifidEn;
    assign idex_en       = ctrl.idexEn;
    assign exmem_en      = ctrl.exmemEn;
    assign memwb_en      = ctrl.memwbEn;
    assign ifid_flush    = ctrl.ifidFlush;
    assign idex_flush    = ctrl.idexFlush;
    assign exmem_flush   = ctrl.exmemFlush;
    assign memwb_flush   = ctrl.memwbFlush;
    assign dmem_req      = ctrl.dmemReq;
    assign mem_err       = memErr;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (INIT_CYCLES=5, MEM_TIMEOUT=4); counters checked when
// PIPE_PERF_CNT_EN is defined.
module tb_pipe_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read;
    logic       mem_mem_read, mem_mem_write, mem_redirect, dmem_ready;
    logic       pc_en, pc_sel_target, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, err_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pipe_stall_ctrl #(
        .INIT_CYCLES (5),
        .MEM_TIMEOUT (4)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_W     (16)
`endif
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_redirect  (mem_redirect),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .pc_sel_target (pc_sel_target),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .dmem_req      (dmem_req),
        .mem_err       (mem_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .err_cnt       (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_redirect = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic chkMemStall(input string tag);
        chk({tag, ".pc_en"}, pc_en, 1'b0);
        chk({tag, ".ifid_en"}, ifid_en, 1'b0);
        chk({tag, ".exmem_en"}, exmem_en, 1'b0);
        chk({tag, ".memwb_flush"}, memwb_flush, 1'b1);
        chk({tag, ".dmem_req"}, dmem_req, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        #2;
        chk("rst.pc_en", pc_en, 1'b0);
        chk("rst.memwb_en", memwb_en, 1'b0);
        chk("rst.ifid_flush", ifid_flush, 1'b1);
        chk("rst.memwb_flush", memwb_flush, 1'b1);
        chk("rst.dmem_req", dmem_req, 1'b0);
        chk("rst.mem_err", mem_err, 1'b0);
        tick();
        reset = 1'b0;
        #1;

        // Post-reset clear: five flush cycles with the PC held, then RUN
        for (int i = 0; i < 5; i++) begin
            chk("init.ifid_flush", ifid_flush, 1'b1);
            chk("init.memwb_flush", memwb_flush, 1'b1);
            chk("init.ifid_en", ifid_en, 1'b1);
            chk("init.pc_en", pc_en, 1'b0);
            tick();
        end
        chk("run.pc_en", pc_en, 1'b1);
        chk("run.ifid_flush", ifid_flush, 1'b0);
        chk("run.memwb_flush", memwb_flush, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf.stall0", stall_cnt, 16'd0);
`endif

        // Load-use on rs: one interlock cycle
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #1;
        chk("lu.pc_en", pc_en, 1'b0);
        chk("lu.ifid_en", ifid_en, 1'b0);
        chk("lu.idex_flush", idex_flush, 1'b1);
        chk("lu.exmem_en", exmem_en, 1'b1);
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu.after.pc_en", pc_en, 1'b1);
        chk("lu.after.idex_flush", idex_flush, 1'b0);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu.r0.pc_en", pc_en, 1'b1);
        chk("lu.r0.idex_flush", idex_flush, 1'b0);
        ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1;
        chk("lu.rt.pc_en", pc_en, 1'b0);
        id_uses_rt = 1'b0;
        #1;
        chk("lu.rt_unused.pc_en", pc_en, 1'b1);
        clearInputs();
        tick();

        // Memory wait: four stalled cycles, then everything advances on ready
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chkMemStall("mwait");
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("mrdy.pc_en", pc_en, 1'b1);
        chk("mrdy.exmem_en", exmem_en, 1'b1);
        chk("mrdy.memwb_flush", memwb_flush, 1'b0);
        chk("mrdy.dmem_req", dmem_req, 1'b1);
        tick();
        mem_mem_read = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("mrdy.after.pc_en", pc_en, 1'b1);
        mem_mem_write = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("single.pc_en", pc_en, 1'b1);
        chk("single.dmem_req", dmem_req, 1'b1);
        tick();
        mem_mem_write = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("single.after.pc_en", pc_en, 1'b1);
        chk("single.after.dmem_req", dmem_req, 1'b0);

        // Redirect together with load-use: redirect wins
        mem_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #1;
        chk("redir.pc_en", pc_en, 1'b1);
        chk("redir.pc_sel_target", pc_sel_target, 1'b1);
        chk("redir.ifid_flush", ifid_flush, 1'b1);
        chk("redir.idex_flush", idex_flush, 1'b1);
        chk("redir.exmem_flush", exmem_flush, 1'b1);
        chk("redir.memwb_flush", memwb_flush, 1'b0);
        chk("redir.ifid_en", ifid_en, 1'b1);
        tick();
        clearInputs();
        #1;
        chk("redir.after.pc_sel_target", pc_sel_target, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf.stall", stall_cnt, 16'd5);
        chk("perf.flush", flush_cnt, 16'd1);
        chk("perf.err0", err_cnt, 16'd0);
`endif

        // Timeout: one RUN stall plus four wait cycles, then ERR
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chkMemStall("tmo");
            chk("tmo.mem_err", mem_err, 1'b0);
            tick();
        end
        chk("err.mem_err", mem_err, 1'b1);
        chk("err.pc_en", pc_en, 1'b0);
        chk("err.memwb_en", memwb_en, 1'b0);
        chk("err.memwb_flush", memwb_flush, 1'b0);
        chk("err.ifid_flush", ifid_flush, 1'b0);
        chk("err.dmem_req", dmem_req, 1'b0);
        dmem_ready = 1'b1;
        tick();
        chk("err.sticky.mem_err", mem_err, 1'b1);
        chk("err.sticky.pc_en", pc_en, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf.err", err_cnt, 16'd1);
        chk("perf.stall_tmo", stall_cnt, 16'd10);
`endif
        clearInputs();
        reset = 1'b1;
        #1;
        chk("err.rst.mem_err", mem_err, 1'b0);
        chk("err.rst.ifid_flush", ifid_flush, 1'b1);
`ifdef PIPE_PERF_CNT_EN
        chk("perf.rst", stall_cnt, 16'd0);
`endif
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rerun.pc_en", pc_en, 1'b1);

        // Reset in the middle of a memory wait abandons the access
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        chkMemStall("midstall");
        reset = 1'b1;
        #1;
        chk("midrst.dmem_req", dmem_req, 1'b0);
        chk("midrst.ifid_en", ifid_en, 1'b0);
        tick();
        reset = 1'b0;
        clearInputs();
        #1;
        chk("midrst.init.pc_en", pc_en, 1'b0);
        chk("midrst.init.ifid_flush", ifid_flush, 1'b1);
        chk("midrst.init.dmem_req", dmem_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
